// File: rtl/wb_trace_pkg.sv
// Shared types and entry-width helper for the pipeline-retire trace buffer.
package wb_trace_pkg;

    typedef enum logic {
        TRC_WB    = 1'b0,
        TRC_REDIR = 1'b1
    } trace_kind_e;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int TS_W_DEF   = 32;

    // One stored entry is {kind, rd, data, timestamp}; ts_w may be 0 when no stamp is kept.
    function automatic int entry_w(input int xlen, input int reg_aw, input int ts_w);
        return 1 + reg_aw + xlen + ts_w;
    endfunction

    localparam int ENTRY_W = entry_w(XLEN_DEF, REG_AW_DEF, TS_W_DEF);

    typedef struct packed {
        trace_kind_e            kind;
        logic [REG_AW_DEF-1:0]  rd;
        logic [XLEN_DEF-1:0]    data;
        logic [TS_W_DEF-1:0]    ts;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_2w.sv
// Show-ahead FIFO with two write ports and one read port. The caller guarantees
// there is room for every push and never pops while empty.
module trace_fifo_2w
    import wb_trace_pkg::*;
#(
    parameter int W     = ENTRY_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push_a,
    input  logic [W-1:0]               data_a,
    input  logic                       push_b,
    input  logic [W-1:0]               data_b,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_b;
    logic [LW-1:0] level_q;

    // Port b lands right behind port a when both write in the same cycle.
    assign wr_ptr_b = push_a ? wr_ptr + AW'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr]   <= data_a;
        if (push_b) mem[wr_ptr_b] <= data_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr  <= rd_ptr + AW'(pop);
            level_q <= level_q + LW'(push_a) + LW'(push_b) - LW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign level = level_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback/redirect trace capture with drop accounting; never stalls the core.
// Optional per-entry cycle timestamp: define WB_TRACE_TIMESTAMP_EN.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       wb_valid_i,
    input  logic [REG_AW-1:0]          wb_rd_i,
    input  logic [XLEN-1:0]            wb_data_i,
    input  logic                       redir_valid_i,
    input  logic [XLEN-1:0]            redir_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_kind_o,
    output logic [REG_AW-1:0]          out_rd_o,
    output logic [XLEN-1:0]            out_data_o,
    output logic [TS_W-1:0]            out_ts_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic                       overflow_o
);

    localparam int LW  = $clog2(DEPTH+1);
    localparam int FW  = LW + 1;
    localparam int DW1 = DROP_W + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int TS_ST = TS_W;
`else
    localparam int TS_ST = 0;
`endif
    localparam int EW = entry_w(XLEN, REG_AW, TS_ST);

    logic [EW-1:0]     ent_wb;
    logic [EW-1:0]     ent_redir;
    logic [EW-1:0]     head;
    logic              wb_ev;
    logic              pop;
    logic [FW-1:0]     free;
    logic              wb_store;
    logic              redir_store;
    logic [1:0]        ndrop;
    logic [DW1-1:0]    drop_sum;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running; clr_i deliberately leaves it alone so stamps stay monotonic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    assign ent_wb    = {TRC_WB, wb_rd_i, wb_data_i, ts_q};
    assign ent_redir = {TRC_REDIR, {REG_AW{1'b0}}, redir_pc_i, ts_q};
    assign out_ts_o  = head[TS_W-1:0];
`else
    assign ent_wb    = {TRC_WB, wb_rd_i, wb_data_i};
    assign ent_redir = {TRC_REDIR, {REG_AW{1'b0}}, redir_pc_i};
    assign out_ts_o  = '0;
`endif

    assign out_valid_o = (level_o != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign wb_ev       = wb_valid_i & (wb_rd_i != '0);

    // Space counts the slot vacated by a same-cycle pop; WB wins the last slot.
    always_comb begin
        free        = FW'(DEPTH) - {1'b0, level_o} + FW'(pop);
        wb_store    = wb_ev & (free >= FW'(1));
        redir_store = redir_valid_i & (free >= (wb_store ? FW'(2) : FW'(1)));
        ndrop       = {1'b0, wb_ev & ~wb_store} + {1'b0, redir_valid_i & ~redir_store};
        drop_sum    = {1'b0, drop_q} + DW1'(ndrop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (ndrop != 2'd0) begin
            drop_q <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            ovf_q  <= 1'b1;
        end
    end

    trace_fifo_2w #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_i),
        .push_a (wb_store & ~clr_i),
        .data_a (ent_wb),
        .push_b (redir_store & ~clr_i),
        .data_b (ent_redir),
        .pop    (pop & ~clr_i),
        .head   (head),
        .level  (level_o)
    );

    assign out_kind_o = head[EW-1];
    assign out_rd_o   = head[TS_ST+XLEN +: REG_AW];
    assign out_data_o = head[TS_ST +: XLEN];
    assign drop_cnt_o = drop_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed table-driven bench for wb_trace_buffer plus overflow, wrap, clear and timestamp sequences.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        redir_valid_i;
    logic [31:0] redir_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_kind_o;
    logic [4:0]  out_rd_o;
    logic [31:0] out_data_o;
    logic [31:0] out_ts_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    wb_trace_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (clr_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_kind_o    (out_kind_o),
        .out_rd_o      (out_rd_o),
        .out_data_o    (out_data_o),
        .out_ts_o      (out_ts_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_v;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rv;
        logic [31:0] pc;
        logic        rdy;
        logic        e_valid;
        logic        e_kind;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [4:0]  e_level;
    } vec_t;

    vec_t        vt[11];
    logic [37:0] exp_q[$];
    logic [37:0] exp_e;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(logic wb_v, logic [4:0] rd, logic [31:0] data, logic rv,
                                logic [31:0] pc, logic rdy, logic e_valid, logic e_kind,
                                logic [4:0] e_rd, logic [31:0] e_data, logic [4:0] e_level);
        vec_t v;
        v.wb_v = wb_v; v.rd = rd; v.data = data; v.rv = rv; v.pc = pc; v.rdy = rdy;
        v.e_valid = e_valid; v.e_kind = e_kind; v.e_rd = e_rd; v.e_data = e_data;
        v.e_level = e_level;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic wb_v, input logic [4:0] rd, input logic [31:0] data,
                         input logic rv, input logic [31:0] pc, input logic rdy, input logic clr);
        wb_valid_i    = wb_v;
        wb_rd_i       = rd;
        wb_data_i     = data;
        redir_valid_i = rv;
        redir_pc_i    = pc;
        out_ready_i   = rdy;
        clr_i         = clr;
    endtask

    task automatic chk_head(input string name, input logic [37:0] e);
        chk({name, ".valid"}, 64'(out_valid_o), 64'd1);
        chk({name, ".entry"}, 64'({out_kind_o, out_rd_o, out_data_o}), 64'(e));
    endtask

    task automatic chk_stat(input string name, input logic [4:0] lvl, input logic [15:0] drop,
                            input logic ovf);
        chk({name, ".level"}, 64'(level_o), 64'(lvl));
        chk({name, ".drop"}, 64'(drop_cnt_o), 64'(drop));
        chk({name, ".ovf"}, 64'(overflow_o), 64'(ovf));
    endtask

    initial begin
        // Table: basic capture, filtering, dual write ordering, redirect-only and pop+push.
        vt[0]  = mk(0, 0,  32'h0,        0, 32'h0,  0, 0, 0, 0,  32'h0,        0);
        vt[1]  = mk(1, 3,  32'hDEADBEEF, 0, 32'h0,  0, 1, 0, 3,  32'hDEADBEEF, 1);
        vt[2]  = mk(1, 0,  32'h00000001, 0, 32'h0,  0, 1, 0, 3,  32'hDEADBEEF, 1);
        vt[3]  = mk(0, 0,  32'h0,        0, 32'h0,  1, 0, 0, 0,  32'h0,        0);
        vt[4]  = mk(1, 5,  32'h10,       1, 32'h80, 0, 1, 0, 5,  32'h10,       2);
        vt[5]  = mk(0, 0,  32'h0,        0, 32'h0,  1, 1, 1, 0,  32'h80,       1);
        vt[6]  = mk(0, 0,  32'h0,        0, 32'h0,  1, 0, 0, 0,  32'h0,        0);
        vt[7]  = mk(0, 0,  32'h0,        1, 32'h44, 0, 1, 1, 0,  32'h44,       1);
        vt[8]  = mk(1, 0,  32'h99,       1, 32'h48, 1, 1, 1, 0,  32'h48,       1);
        vt[9]  = mk(1, 31, 32'hCAFE0001, 0, 32'h0,  1, 1, 0, 31, 32'hCAFE0001, 1);
        vt[10] = mk(0, 0,  32'h0,        0, 32'h0,  1, 0, 0, 0,  32'h0,        0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset.valid", 64'(out_valid_o), 64'd0);
        chk_stat("reset", 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].wb_v, vt[i].rd, vt[i].data, vt[i].rv, vt[i].pc, vt[i].rdy, 0);
            step();
            chk($sformatf("vec%0d.valid", i), 64'(out_valid_o), 64'(vt[i].e_valid));
            chk_stat($sformatf("vec%0d", i), vt[i].e_level, 0, 0);
            if (vt[i].e_valid)
                chk_head($sformatf("vec%0d", i), {vt[i].e_kind, vt[i].e_rd, vt[i].e_data});
        end

        // Fill 15 with the consumer stalled, then overflow with dual events.
        for (int i = 0; i < 15; i++) begin
            drive(1, 5'(i + 1), 32'h1000 + 32'(i), 0, 0, 0, 0);
            step();
            exp_q.push_back({1'b0, 5'(i + 1), 32'h1000 + 32'(i)});
        end
        chk_stat("fill15", 15, 0, 0);
        chk_head("fill15", exp_q[0]);

        drive(1, 20, 32'h2000, 1, 32'h3000, 0, 0);
        step();
        exp_q.push_back({1'b0, 5'd20, 32'h2000});
        chk_stat("ovf1", 16, 1, 1);

        drive(1, 21, 32'h2100, 1, 32'h3100, 0, 0);
        step();
        chk_stat("ovf2", 16, 3, 1);

        drive(1, 22, 32'h2200, 1, 32'h3200, 1, 0);
        step();
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, 5'd22, 32'h2200});
        chk_stat("full_pop", 16, 4, 1);

        // Drain and confirm order end to end.
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            exp_e = exp_q.pop_front();
            chk_head($sformatf("drain%0d", i), exp_e);
            step();
        end
        chk("drained.valid", 64'(out_valid_o), 64'd0);
        chk_stat("drained", 0, 4, 1);

        // Push every cycle with ready held high: pointers wrap, level stays at 1.
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                chk_head($sformatf("wrap%0d", i), exp_e);
                chk($sformatf("wrap%0d.level", i), 64'(level_o), 64'd1);
            end
            drive(1, 5'((i % 31) + 1), 32'h5000 + 32'(i), 0, 0, 1, 0);
            step();
            exp_e = {1'b0, 5'((i % 31) + 1), 32'h5000 + 32'(i)};
        end
        chk_head("wrap_last", exp_e);

        // Clear wins over a same-cycle event.
        drive(1, 7, 32'h7777, 1, 32'h7000, 0, 1);
        step();
        chk("clr.valid", 64'(out_valid_o), 64'd0);
        chk_stat("clr", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_stat("post_clr", 0, 0, 0);

        // Timestamp: re-reset, events presented in cycles 10 and 12 after release.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 10)      drive(1, 9,  32'hA, 0, 0, 0, 0);
            else if (c == 12) drive(1, 10, 32'hC, 0, 0, 0, 0);
            else              drive(0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        chk_stat("ts", 2, 0, 0);
        chk_head("ts0", {1'b0, 5'd9, 32'hA});
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts0.ts", 64'(out_ts_o), 64'd10);
`else
        chk("ts0.ts", 64'(out_ts_o), 64'd0);
`endif
        step();
        chk_head("ts1", {1'b0, 5'd10, 32'hC});
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts1.ts", 64'(out_ts_o), 64'd12);
`else
        chk("ts1.ts", 64'(out_ts_o), 64'd0);
`endif
        step();
        chk("ts_end.valid", 64'(out_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Synthesizable capture buffer for pipeline-retire events in the pipelined RV32 core.
- Two channels are recorded:
  - register writeback (RegWrite_W/rd_W/result_W);
  - control-flow redirect (PCSrc_E with target PC).
- Events go into a parametrised FIFO with a valid/ready drain port, so a debug or trace consumer can read the architectural trace without stalling the core.
- Overflowing events are dropped and counted; the core is never back-pressured.

Parameters:
- XLEN, 32, data/PC width.
- REG_AW, 5, register address width.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TS_W, 32, timestamp width; used only with the optional feature.
- DROP_W, 16, drop counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear: flushes FIFO, drop_cnt_o and overflow_o.
- wb_valid_i  in  1  writeback event (RegWrite_W).
- wb_rd_i  in  REG_AW  destination register (rd_W).
- wb_data_i  in  XLEN  written value (result_W).
- redir_valid_i  in  1  redirect event (PCSrc_E).
- redir_pc_i  in  XLEN  redirect target PC.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_kind_o  out  1  0 = WB, 1 = REDIR.
- out_rd_o  out  REG_AW  rd (0 for REDIR).
- out_data_o  out  XLEN  result or target PC.
- out_ts_o  out  TS_W  capture timestamp.
- level_o  out  $clog2(DEPTH+1)  occupied entries.
- drop_cnt_o  out  DROP_W  dropped-event count.
- overflow_o  out  1  sticky drop flag.

Behaviour:
- Reset (async, rst_n low): pointers, level_o, drop_cnt_o, overflow_o, timestamp = 0; out_valid_o = 0; entry storage is not reset.
- Filtering: a WB event with wb_rd_i == 0 is discarded silently. It is neither stored nor counted as a drop.
- Capture: accepted events are written on the clk edge of the cycle they are presented.
  - Show-ahead FIFO: an event presented in cycle N appears at the outputs in cycle N+1 when the FIFO was empty.
  - out_* are driven from storage[rd_ptr] and are don't-care while out_valid_o = 0.
- Dual write: if WB and REDIR events are both valid in one cycle, WB is written at wr_ptr and REDIR at wr_ptr+1. wr_ptr advances by the number of events written (0..2).
- Free space: free = DEPTH - level + pop, where pop = out_valid_o & out_ready_i in the same cycle.
  - free >= 2: both events are stored.
  - free == 1: WB is stored, REDIR is dropped.
  - free == 0: both events are dropped.
- Drops: each dropped event increments drop_cnt_o by 1, so two drops in one cycle add 2. drop_cnt_o saturates at 2^DROP_W-1. overflow_o sets on any drop and holds until clr_i or reset.
- Pop: on out_valid_o & out_ready_i, rd_ptr increments. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Level: level_o = level + pushes - pop, updated every cycle. It never exceeds DEPTH and never goes below 0.
- clr_i has priority over push, pop and drop in the same cycle.
  - Pointers, level, drop_cnt and overflow go to 0, and same-cycle events are discarded.
  - The timestamp is not cleared.
- Consumer contract: out_ready_i may be held high continuously. out_* stay stable while out_valid_o & !out_ready_i.

Optional Feature:
- Macro: WB_TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit cycle counter increments every clk and wraps to 0.
  - Each entry stores the counter value of its capture cycle; both same-cycle events carry the same timestamp.
- Undefined: no counter and no storage; out_ts_o is tied to 0.

Decomposition:
- Package wb_trace_pkg:
  - trace_kind_e {TRC_WB = 1'b0, TRC_REDIR = 1'b1}.
  - Localparam ENTRY_W helper function.
  - Packed trace_entry_t built from the default widths.
- Sub-module trace_fifo_2w: a parametrised FIFO with 2 write ports and 1 read port, covering storage, pointers and level. The top level keeps the filter, the space/drop arbitration, the counters and the timestamp.

Test Plan:
- Reset, then WB events rd=3 data=0xDEADBEEF and rd=0 data=0x1 → one entry (kind 0, rd 3, 0xDEADBEEF) with out_valid_o high one cycle later; level_o = 1.
- WB (rd=5, 0x10) and REDIR (pc 0x80) in the same cycle with an empty FIFO → pops return WB, then REDIR (kind 1, rd 0, 0x80); level_o = 2.
- out_ready_i = 0, DEPTH=16, 15 WB events, then WB+REDIR in one cycle → WB stored, level_o = 16, drop_cnt_o = 1, overflow_o = 1; next dual event → drop_cnt_o = 3.
- FIFO full with out_ready_i = 1 and WB+REDIR in the same cycle → pop frees 1 slot; WB stored, REDIR dropped; level_o stays 16.
- 40 push/pop pairs at DEPTH=16 → FIFO order preserved across pointer wrap; level_o is never above 1. Then clr_i while an event is valid → level_o = 0, drop_cnt_o = 0, overflow_o = 0, event discarded.
- With WB_TRACE_TIMESTAMP_EN: events at cycles 10 and 12 after reset release → out_ts_o = 10, then 12. Without the macro, out_ts_o = 0.
